// File: rtl/exclusive_max_n.sv
// Exclusive-max over N race-logic pulse inputs within one gamma cycle.
// Fires a fixed-width pulse at the latest arrival when that arrival is unique.
module exclusive_max_n #(
  parameter int N_IN              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH),
  localparam int IW = $clog2(N_IN)
) (
  input  logic            aclk,
  input  logic            grst_n,
  input  logic [N_IN-1:0] a,
  output logic            q,
  output logic [IW-1:0]   q_idx,
  output logic [TW-1:0]   q_time,
  output logic            tie,
  output logic            gamma_start
);

  localparam int PWW = $clog2(PULSE_WIDTH + 1);
  localparam logic [TW-1:0] CMAX = TW'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_FIRE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] a_prev_q, a_prev_d;
  logic [N_IN-1:0] seen_q, seen_d;
  logic            q_q, q_d;
  logic [IW-1:0]   q_idx_q, q_idx_d;
  logic [TW-1:0]   q_time_q, q_time_d;
  logic            tie_q, tie_d;
  logic [PWW-1:0]  pw_cnt_q, pw_cnt_d;

  logic [N_IN-1:0] rise_new;
  logic            one_hot;
  logic [IW-1:0]   win_idx;
  logic            wrap;

  // Re-rises on channels already seen this gamma never count as arrivals.
  always_comb begin
    rise_new = a & ~a_prev_q & ~seen_q;
    one_hot  = (rise_new != '0) &&
               ((rise_new & (rise_new - N_IN'(1))) == '0);
    win_idx  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (rise_new[i]) win_idx = IW'(i);
    end
  end

  always_comb begin
    wrap     = (cnt_q == CMAX);
    cnt_d    = wrap ? '0 : cnt_q + TW'(1);
    a_prev_d = a;
    state_d  = state_q;
    seen_d   = seen_q;
    q_d      = q_q;
    q_idx_d  = q_idx_q;
    q_time_d = q_time_q;
    tie_d    = 1'b0;
    pw_cnt_d = pw_cnt_q;
    unique case (state_q)
      S_COLLECT: begin
        seen_d = seen_q | rise_new;
        if (&seen_d) begin
          if (one_hot) begin
            q_d      = 1'b1;
            q_idx_d  = win_idx;
            q_time_d = cnt_q;
            pw_cnt_d = PWW'(PULSE_WIDTH - 1);
            state_d  = S_FIRE;
          end else begin
            tie_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_FIRE: begin
        if (pw_cnt_q == '0) begin
          q_d     = 1'b0;
          state_d = S_DONE;
        end else begin
          pw_cnt_d = pw_cnt_q - PWW'(1);
        end
      end
      S_DONE: begin
      end
      default: state_d = S_COLLECT;
    endcase
    // The gamma boundary wins over any completion or pulse in flight.
    if (wrap) begin
      state_d  = S_COLLECT;
      seen_d   = '0;
      q_d      = 1'b0;
      tie_d    = 1'b0;
      q_idx_d  = '0;
      q_time_d = '0;
      pw_cnt_d = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      state_q  <= S_COLLECT;
      cnt_q    <= '0;
      a_prev_q <= '0;
      seen_q   <= '0;
      q_q      <= 1'b0;
      q_idx_q  <= '0;
      q_time_q <= '0;
      tie_q    <= 1'b0;
      pw_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_prev_q <= a_prev_d;
      seen_q   <= seen_d;
      q_q      <= q_d;
      q_idx_q  <= q_idx_d;
      q_time_q <= q_time_d;
      tie_q    <= tie_d;
      pw_cnt_q <= pw_cnt_d;
    end
  end

  assign q           = q_q;
  assign q_idx       = q_idx_q;
  assign q_time      = q_time_q;
  assign tie         = tie_q;
  assign gamma_start = (cnt_q == '0);

endmodule

// File: tb/tb_exclusive_max_n.sv
// Directed bench for exclusive_max_n with a per-gamma arrival-time model.
// Arrival times are recorded per channel; expected outputs follow from them.
module tb_exclusive_max_n;

  localparam int N  = 4;
  localparam int G  = 16;
  localparam int PW = 8;

  typedef logic [G-1:0][N-1:0] tbl_t;

  logic       aclk = 1'b0;
  logic       grst_n;
  logic [3:0] a;
  logic       q;
  logic [1:0] q_idx;
  logic [3:0] q_time;
  logic       tie;
  logic       gamma_start;

  int n_vec = 0;
  int n_miss = 0;

  int         arr [N];
  logic [3:0] prev_m;
  int         mc;

  exclusive_max_n #(
    .N_IN(N),
    .GAMMA_CYCLE_WIDTH(G),
    .PULSE_WIDTH(PW)
  ) dut (
    .aclk(aclk),
    .grst_n(grst_n),
    .a(a),
    .q(q),
    .q_idx(q_idx),
    .q_time(q_time),
    .tie(tie),
    .gamma_start(gamma_start)
  );

  always #5 aclk = ~aclk;

  function automatic tbl_t mk(input int t0, input int t1,
                              input int t2, input int t3);
    tbl_t t;
    int   tt [N];
    t = '0;
    tt[0] = t0; tt[1] = t1; tt[2] = t2; tt[3] = t3;
    for (int i = 0; i < N; i++)
      if (tt[i] >= 0) t[tt[i]][i] = 1'b1;
    return t;
  endfunction

  task automatic clr_model();
    for (int i = 0; i < N; i++) arr[i] = -1;
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL lit %s cnt=%0d got=%0d want=%0d", nm, mc, act, exp);
    end
  endtask

  // Expected outputs for cycle mc from arrivals strictly before mc.
  task automatic check();
    int   last, nl, win;
    bit   comp, uniq;
    logic [8:0] act, exp;
    last = -1; nl = 0; win = 0; comp = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (arr[i] < 0) comp = 1'b0;
      else if (arr[i] > last) begin
        last = arr[i]; nl = 1; win = i;
      end else if (arr[i] == last) nl++;
    end
    uniq = comp && nl == 1 && mc > last;
    exp = {uniq && mc <= last + PW,
           2'(uniq ? win : 0),
           4'(uniq ? last : 0),
           comp && nl > 1 && mc == last + 1,
           mc == 0};
    act = {q, q_idx, q_time, tie, gamma_start};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL cyc cnt=%0d {q,idx,time,tie,gs} got=%b want=%b",
               mc, act, exp);
    end
  endtask

  // Check current cycle, drive inputs for it, advance model and clock.
  task automatic cyc(input logic [3:0] av, input logic rv);
    check();
    a = av;
    grst_n = rv;
    if (!rv) begin
      mc = 0;
      prev_m = '0;
      clr_model();
    end else begin
      for (int i = 0; i < N; i++)
        if (av[i] && !prev_m[i] && arr[i] < 0) arr[i] = mc;
      prev_m = av;
      mc = (mc + 1) % G;
      if (mc == 0) clr_model();
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic gamma(input tbl_t t, input int sc, input int rst_at);
    if (mc != 0) begin
      n_vec++; n_miss++;
      $display("FAIL align cnt=%0d want=0", mc);
    end
    for (int c = 0; c < G; c++) begin
      case (sc)
        2: begin
          if (c == 6) begin
            lit("s2_q", int'(q), 1);
            lit("s2_idx", int'(q_idx), 2);
            lit("s2_time", int'(q_time), 5);
          end
          if (c == 14) lit("s2_q_end", int'(q), 0);
          if (c == 15) lit("s2_idx_hold", int'(q_idx), 2);
        end
        3: begin
          if (c == 8) lit("s3_tie", int'(tie), 1);
          if (c == 9) lit("s3_tie_end", int'(tie), 0);
        end
        4: if (c == 5) lit("s4_q", int'(q), 0);
        5: begin
          if (c == 13) lit("s5_q", int'(q), 1);
          if (c == 15) lit("s5_time", int'(q_time), 12);
        end
        51: if (c == 0) begin
          lit("s5_q_wrap", int'(q), 0);
          lit("s5_idx_wrap", int'(q_idx), 0);
          lit("s5_time_wrap", int'(q_time), 0);
        end
        7: if (c == 8) lit("s7_idx", int'(q_idx), 3);
        default: ;
      endcase
      cyc(t[c], c != rst_at);
      if (c == rst_at) break;
    end
  endtask

  initial begin
    tbl_t t;
    a = '0;
    grst_n = 1'b0;
    prev_m = '0;
    clr_model();
    repeat (2) @(posedge aclk);
    #1;
    mc = 0;
    lit("rst_q", int'(q), 0);
    lit("rst_gs", int'(gamma_start), 1);

    gamma('0, 0, -1);
    gamma('0, 0, -1);
    gamma(mk(2, 4, 5, 3), 2, -1);
    gamma(mk(2, 2, 7, 7), 3, -1);
    gamma(mk(1, 2, 3, 4), 0, -1);
    gamma(mk(2, 3, 4, -1), 0, -1);
    gamma(mk(-1, -1, -1, 1), 4, -1);
    gamma(mk(1, 2, 3, 12), 5, -1);
    gamma('0, 51, -1);

    // Re-rise of a seen channel alongside the true last arrival.
    t = mk(2, 3, 4, 7);
    t[7][0] = 1'b1;
    gamma(t, 7, -1);

    // Level held across the wrap does not arrive again.
    t = mk(1, 2, 3, -1);
    t[14][3] = 1'b1;
    t[15][3] = 1'b1;
    gamma(t, 0, -1);
    t = mk(-1, 3, 4, 5);
    t[0][3] = 1'b1;
    t[1][3] = 1'b1;
    gamma(t, 0, -1);

    // Completion on the last count of the gamma loses to the wrap.
    gamma(mk(1, 2, 3, 15), 0, -1);
    gamma(mk(3, 3, 3, 3), 0, -1);

    // Reset mid-pulse.
    gamma(mk(2, 4, 5, 3), 0, 9);
    lit("s6_q", int'(q), 0);
    lit("s6_gs", int'(gamma_start), 1);
    gamma('0, 0, -1);
    gamma(mk(0, 1, 2, 3), 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
